bin2bcd_n: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per enabled clock.
- Sits between binary counters/registers and decimal display or ASCII formatting logic.
- Start/done handshake. Result is held stable until the next conversion completes.

---
 rtl/bin2bcd_n.sv | 108 ++++++++++
 tb/tb_bin2bcd_n.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_n.sv
// bin2bcd_n: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts one input bit per enabled clock. Uses a start/done handshake, and the
// result stays held until the next conversion completes.
// Optional feature: define BIN2BCD_N_ASCII_EN to add the dat_ascii_o output,
// which holds the zero-padded ASCII form of the result.
module bin2bcd_n #(
    parameter int unsigned W      = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  start_i,
    input  logic [W-1:0]          dat_binary_i,
    output logic [4*DIGITS-1:0]   dat_bcd_o,
`ifdef BIN2BCD_N_ASCII_EN
    output logic [8*DIGITS-1:0]   dat_ascii_o,
`endif
    output logic                  done_o
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q;
    logic [W-1:0]         bin_q;
    logic [4*DIGITS-1:0]  acc_q;
    logic [CW-1:0]        cnt_q;
    logic [4*DIGITS-1:0]  acc_adj;

    // Add 3 to every accumulator digit that is 5 or more. Each digit is
    // adjusted independently; there is no carry between digits.
    always_comb begin
        acc_adj = acc_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_N_ASCII_EN
    logic [8*DIGITS-1:0] ascii_next;

    // Form the ASCII digits from the accumulator. Byte k corresponds to BCD digit k.
    always_comb begin
        ascii_next = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            ascii_next[8*k +: 8] = 8'h30 + {4'h0, acc_q[4*k +: 4]};
        end
    end
`endif

    // Control FSM and datapath. All state freezes while ce_i is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            dat_bcd_o <= '0;
            done_o    <= 1'b0;
`ifdef BIN2BCD_N_ASCII_EN
            dat_ascii_o <= {DIGITS{8'h30}};
`endif
        end else if (ce_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q   <= dat_binary_i;
                        acc_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        done_o  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shift {adjusted accumulator, binary} left by one bit.
                    acc_q <= {acc_adj[4*DIGITS-2:0], bin_q[W-1]};
                    bin_q <= {bin_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    dat_bcd_o <= acc_q;
`ifdef BIN2BCD_N_ASCII_EN
                    dat_ascii_o <= ascii_next;
`endif
                    done_o  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_n.sv
// tb_bin2bcd_n: self-checking bench for bin2bcd_n. It uses a cycle-level
// reference model built from decimal arithmetic plus directed checks against
// literal values.
`timescale 1ns/1ps
module tb_bin2bcd_n;

    localparam int unsigned W      = 16;
    localparam int unsigned DIGITS = 5;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 ce    = 1'b0;
    logic                 start = 1'b0;
    logic [W-1:0]         din   = '0;
    logic [4*DIGITS-1:0]  bcd;
    logic                 done;
`ifdef BIN2BCD_N_ASCII_EN
    logic [8*DIGITS-1:0]  ascii;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_n #(.W(W), .DIGITS(DIGITS)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ce_i         (ce),
        .start_i      (start),
        .dat_binary_i (din),
        .dat_bcd_o    (bcd),
`ifdef BIN2BCD_N_ASCII_EN
        .dat_ascii_o  (ascii),
`endif
        .done_o       (done)
    );

    // Decimal digits of v, packed 4 bits per digit with digit 0 least significant.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [8*DIGITS-1:0] to_ascii(input int unsigned v);
        logic [8*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[8*k +: 8] = 8'(8'h30 + (x % 10));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. An accepted start publishes to_bcd(value) after W+1
    // further enabled edges (the accepting edge is the load edge).
    logic [4*DIGITS-1:0] m_bcd;
    logic [8*DIGITS-1:0] m_ascii;
    logic                m_done;
    int                  m_busy;
    int unsigned         m_val;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bcd   <= '0;
            m_ascii <= {DIGITS{8'h30}};
            m_done  <= 1'b0;
            m_busy  <= 0;
            m_val   <= 0;
        end else if (ce) begin
            if (m_busy == 0) begin
                if (start) begin
                    m_val  <= din;
                    m_busy <= W + 1;
                    m_done <= 1'b0;
                end
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_bcd   <= to_bcd(m_val);
                    m_ascii <= to_ascii(m_val);
                    m_done  <= 1'b1;
                end
            end
        end
    end

    // Compare the DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        chk("done_model", done, m_done);
        chk("bcd_model", bcd, m_bcd);
`ifdef BIN2BCD_N_ASCII_EN
        chk("ascii_model", ascii, m_ascii);
`endif
    end

    // Count falling edges until done is high, with a bounded wait.
    task automatic wait_done(inout int cnt);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            cnt++;
            guard++;
        end
        if (done !== 1'b1) chk("timeout_done", 64'(done), 64'd1);
    endtask

    // Pulse start for one cycle. On return the accepting edge has just passed.
    task automatic go(input int unsigned v);
        @(negedge clk);
        din   = W'(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic convert(input int unsigned v, input string name, input logic [4*DIGITS-1:0] lit);
        int cnt;
        go(v);
        cnt = 0;
        wait_done(cnt);
        chk({name, "_lat"}, 64'(cnt), 64'(W + 1));
        chk(name, bcd, lit);
    endtask

    initial begin
        int cnt;
        int guard;

        @(negedge clk);
        chk("rst_bcd", bcd, 20'h00000);
        chk("rst_done", 64'(done), 64'd0);
`ifdef BIN2BCD_N_ASCII_EN
        chk("rst_ascii", ascii, 40'h3030303030);
`endif
        rst = 1'b0;
        ce  = 1'b1;
        @(negedge clk);

        // Zero input: done appears on the 18th enabled edge, counting the accepting edge.
        convert(0, "zero", 20'h00000);

        for (int i = 0; i <= 10003; i += 7) begin
            go(i);
            cnt = 0;
            wait_done(cnt);
            if (i == 9996)  chk("sweep_9996", bcd, 20'h09996);
            if (i == 10003) chk("sweep_10003", bcd, 20'h10003);
            if (i == 7)     chk("sweep_7", bcd, 20'h00007);
        end

        convert(9999, "v9999", 20'h09999);
        convert(10, "v10", 20'h00010);
        convert(65535, "vmax", 20'h65535);

        // Stall: five disabled edges mid-conversion delay the result by exactly five edges.
        go(4321);
        cnt = 0;
        repeat (5) begin @(negedge clk); cnt++; end
        ce = 1'b0;
        repeat (5) begin @(negedge clk); cnt++; end
        ce = 1'b1;
        wait_done(cnt);
        chk("stall_lat", 64'(cnt), 64'(W + 1 + 5));
        chk("stall_val", bcd, 20'h04321);

        // Asynchronous reset mid-conversion clears the outputs with no clock edge.
        go(1234);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_bcd", bcd, 20'h00000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A second start issued while busy is ignored.
        go(42);
        cnt = 0;
        repeat (3) begin @(negedge clk); cnt++; end
        din   = W'(999);
        start = 1'b1;
        @(negedge clk);
        cnt++;
        start = 1'b0;
        wait_done(cnt);
        chk("busy_lat", 64'(cnt), 64'(W + 1));
        chk("busy_val", bcd, 20'h00042);

        // Start held high: back-to-back conversions.
        @(negedge clk);
        din   = W'(77);
        start = 1'b1;
        @(negedge clk);
        cnt = 0;
        wait_done(cnt);
        chk("b2b_first", bcd, 20'h00077);
        din = W'(88);
        guard = 0;
        while (done === 1'b1 && guard < 10) begin @(negedge clk); guard++; end
        chk("b2b_drop", 64'(guard), 64'd1);
        cnt = 0;
        wait_done(cnt);
        chk("b2b_lat", 64'(cnt + guard), 64'(W + 2));
        start = 1'b0;
        chk("b2b_second", bcd, 20'h00088);
        @(negedge clk);

`ifdef BIN2BCD_N_ASCII_EN
        convert(905, "v905", 20'h00905);
        chk("ascii_905", ascii, 40'h3030393035);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
